// File: rtl/alu_pkg.sv
// Shared definitions for the multi-lane ALU: operation encodings and the
// signed saturation limits used when ALU_SAT_EN is defined.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101,
        ALU_SLT = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    // Largest positive (neg=0) or most negative (neg=1) signed value of a
    // width-bit word, returned sign-extended to 64 bits; callers take the low bits.
    function automatic logic [63:0] sat_limit(input int width, input logic neg);
        logic [63:0] lim;
        lim = (64'd1 << (width - 1)) - 64'd1;
        return neg ? ~lim : lim;
    endfunction

endpackage

// File: rtl/alu_lane.sv
// One combinational WIDTH-bit ALU lane. Signed saturation of ADD/SUB is
// compiled in with the ALU_SAT_EN macro; otherwise they wrap.
module alu_lane
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] addRes;
    logic [WIDTH-1:0] subRes;
    logic [WIDTH-1:0] raw;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

`ifdef ALU_SAT_EN
    localparam logic [63:0]      MAX64   = sat_limit(WIDTH, 1'b0);
    localparam logic [63:0]      MIN64   = sat_limit(WIDTH, 1'b1);
    localparam logic [WIDTH-1:0] SAT_MAX = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN = MIN64[WIDTH-1:0];

    logic addOvf;
    logic subOvf;

    // Overflow can only happen when the true result's sign disagrees with A,
    // so A's sign picks the clamp direction.
    assign addOvf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1]  != a_i[WIDTH-1]);
    assign subOvf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
    assign addRes = addOvf ? (a_i[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;
    assign subRes = subOvf ? (a_i[WIDTH-1] ? SAT_MIN : SAT_MAX) : diff;
`else
    assign addRes = sum;
    assign subRes = diff;
`endif

    always_comb begin
        raw = '0;
        case (op_i)
            ALU_ADD: raw = addRes;
            ALU_SUB: raw = subRes;
            ALU_MUL: raw = a_i * b_i;
            ALU_AND: raw = a_i & b_i;
            ALU_OR:  raw = a_i | b_i;
            ALU_XOR: raw = a_i ^ b_i;
            ALU_SLT: raw = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SRL: raw = a_i >> b_i[SHW-1:0];
            default: raw = '0;
        endcase
    end

    assign result_o = en_i ? raw : '0;
    assign zero_o   = en_i && (raw == '0);

endmodule

// File: rtl/alu_lanes.sv
// Two-stage pipelined LANES-wide ALU with valid/ready handshake on both sides.
// Build option: ALU_SAT_EN selects signed saturating ADD/SUB in every lane.
module alu_lanes
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ALU_OP_W-1:0]    in_op,
    input  logic [LANES-1:0]       in_mask,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic [LANES-1:0]       out_zero,
    output logic [LANES-1:0]       out_mask
);

    logic                   s1Valid_q,  s1Valid_d;
    alu_op_e                s1Op_q,     s1Op_d;
    logic [LANES-1:0]       s1Mask_q,   s1Mask_d;
    logic [LANES*WIDTH-1:0] s1A_q,      s1A_d;
    logic [LANES*WIDTH-1:0] s1B_q,      s1B_d;
    logic                   s2Valid_q,  s2Valid_d;
    logic [LANES*WIDTH-1:0] s2Result_q, s2Result_d;
    logic [LANES-1:0]       s2Zero_q,   s2Zero_d;
    logic [LANES-1:0]       s2Mask_q,   s2Mask_d;

    logic [LANES*WIDTH-1:0] laneResult;
    logic [LANES-1:0]       laneZero;
    logic                   inAccept;
    logic                   s2Load;

    for (genvar g = 0; g < LANES; g++) begin : gLane
        alu_lane #(.WIDTH(WIDTH)) uLane (
            .op_i     (s1Op_q),
            .a_i      (s1A_q[g*WIDTH +: WIDTH]),
            .b_i      (s1B_q[g*WIDTH +: WIDTH]),
            .en_i     (s1Mask_q[g]),
            .result_o (laneResult[g*WIDTH +: WIDTH]),
            .zero_o   (laneZero[g])
        );
    end

    // S1 can only be blocked when it holds a beat that cannot move into a full,
    // undrained S2; a drain and accept in the same cycle moves every beat at once.
    assign in_ready = !s1Valid_q || !s2Valid_q || out_ready;
    assign inAccept = in_valid && in_ready;
    assign s2Load   = s1Valid_q && (!s2Valid_q || out_ready);

    always_comb begin
        s1Valid_d  = s1Valid_q;
        s1Op_d     = s1Op_q;
        s1Mask_d   = s1Mask_q;
        s1A_d      = s1A_q;
        s1B_d      = s1B_q;
        s2Valid_d  = s2Valid_q;
        s2Result_d = s2Result_q;
        s2Zero_d   = s2Zero_q;
        s2Mask_d   = s2Mask_q;

        if (inAccept) begin
            s1Valid_d = 1'b1;
            s1Op_d    = alu_op_e'(in_op);
            s1Mask_d  = in_mask;
            s1A_d     = in_a;
            s1B_d     = in_b;
        end else if (s2Load) begin
            s1Valid_d = 1'b0;
        end

        if (s2Load) begin
            s2Valid_d  = 1'b1;
            s2Result_d = laneResult;
            s2Zero_d   = laneZero;
            s2Mask_d   = s1Mask_q;
        end else if (out_ready) begin
            s2Valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q  <= 1'b0;
            s1Op_q     <= ALU_ADD;
            s1Mask_q   <= '0;
            s1A_q      <= '0;
            s1B_q      <= '0;
            s2Valid_q  <= 1'b0;
            s2Result_q <= '0;
            s2Zero_q   <= '0;
            s2Mask_q   <= '0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Op_q     <= s1Op_d;
            s1Mask_q   <= s1Mask_d;
            s1A_q      <= s1A_d;
            s1B_q      <= s1B_d;
            s2Valid_q  <= s2Valid_d;
            s2Result_q <= s2Result_d;
            s2Zero_q   <= s2Zero_d;
            s2Mask_q   <= s2Mask_d;
        end
    end

    assign out_valid  = s2Valid_q;
    assign out_result = s2Result_q;
    assign out_zero   = s2Zero_q;
    assign out_mask   = s2Mask_q;

endmodule

// File: tb/tb_alu_lanes.sv
// Self-checking bench for alu_lanes: directed scenarios plus random traffic,
// scored against an arithmetic reference model of the lane operations.
module tb_alu_lanes;

    localparam int WIDTH = 16;
    localparam int LANES = 4;
    localparam int VW    = LANES * WIDTH;
    localparam int SHMOD = 1 << $clog2(WIDTH);
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [VW-1:0]    res;
        logic [LANES-1:0] zero;
        logic [LANES-1:0] mask;
    } beat_t;

    typedef struct {
        logic  outValid;
        logic  inReady;
        logic  accepted;
        logic  outFire;
        beat_t beat;
    } obs_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [LANES-1:0] in_mask;
    logic [VW-1:0]    in_a;
    logic [VW-1:0]    in_b;
    logic             out_valid;
    logic             out_ready;
    logic [VW-1:0]    out_result;
    logic [LANES-1:0] out_zero;
    logic [LANES-1:0] out_mask;

    int    checks   = 0;
    int    failures = 0;
    beat_t expQ[$];

    always #5 clk = ~clk;

    alu_lanes #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_mask    (in_mask),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_mask   (out_mask)
    );

    // Reference: plain integer arithmetic per lane, then reduce modulo 2^WIDTH.
    function automatic beat_t model(input logic [2:0] op, input logic [LANES-1:0] m,
                                    input logic [VW-1:0] a, input logic [VW-1:0] b);
        beat_t  r;
        longint modv = longint'(1) << WIDTH;
        longint maxS = (longint'(1) << (WIDTH - 1)) - 1;
        longint minS = -(longint'(1) << (WIDTH - 1));
        longint ua, ub, sa, sb, v;
        r.res  = '0;
        r.zero = '0;
        r.mask = m;
        for (int i = 0; i < LANES; i++) begin
            ua = longint'(a[i*WIDTH +: WIDTH]);
            ub = longint'(b[i*WIDTH +: WIDTH]);
            sa = (ua > maxS) ? ua - modv : ua;
            sb = (ub > maxS) ? ub - modv : ub;
            case (op)
                3'd0:    v = SAT ? sa + sb : ua + ub;
                3'd1:    v = SAT ? sa - sb : ua - ub;
                3'd2:    v = ua * ub;
                3'd3:    v = ua & ub;
                3'd4:    v = ua | ub;
                3'd5:    v = ua ^ ub;
                3'd6:    v = (sa < sb) ? 1 : 0;
                default: v = ua >> (ub % SHMOD);
            endcase
            if (SAT && op <= 3'd1) begin
                if (v > maxS) v = maxS;
                if (v < minS) v = minS;
            end
            v = ((v % modv) + modv) % modv;
            if (m[i]) begin
                r.res[i*WIDTH +: WIDTH] = v[WIDTH-1:0];
                r.zero[i]               = (v == 0);
            end
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    // Drive one cycle of inputs, sample everything at the falling edge, and
    // queue the model's answer for any beat the DUT accepts at the next edge.
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [LANES-1:0] m,
                                 input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input logic ordy, output obs_t o);
        in_valid  = v;
        in_op     = op;
        in_mask   = m;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        @(negedge clk);
        o.outValid  = out_valid;
        o.inReady   = in_ready;
        o.accepted  = in_valid && in_ready;
        o.outFire   = out_valid && out_ready;
        o.beat.res  = out_result;
        o.beat.zero = out_zero;
        o.beat.mask = out_mask;
        if (o.accepted) expQ.push_back(model(op, m, a, b));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_mask   = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_result !== '0 || out_zero !== '0 || out_mask !== '0) begin
            failures++; $display("[TB] FAIL reset_payload: got res=%h zero=%b mask=%b want all 0", out_result, out_zero, out_mask);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL post_reset: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_add();
        obs_t  o;
        beat_t e;
        // -1 + 1 is 0 in signed arithmetic too, so lane 3 is zero with or without saturation.
        applyStimulus(1'b1, 3'd0, 4'b1111, {16'hFFFF, 16'd3, 16'd2, 16'd1},
                      {16'd1, 16'd3, 16'd2, 16'd1}, 1'b1, o);
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, o);
        checks++;
        if (o.outValid !== 1'b0) begin failures++; $display("[TB] FAIL add_early: out_valid got %b want 0 one cycle after accept", o.outValid); end
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, o);
        checks++;
        if (o.outValid !== 1'b1) begin failures++; $display("[TB] FAIL add_latency: out_valid got %b want 1", o.outValid); end
        checks++;
        if (o.beat.res !== 64'h0000_0006_0004_0002 || o.beat.zero !== 4'b1000 || o.beat.mask !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL add_value: got res=%h zero=%b mask=%b want res=0000000600040002 zero=1000 mask=1111",
                     o.beat.res, o.beat.zero, o.beat.mask);
        end
        if (expQ.size() > 0) e = expQ.pop_front();
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, o);
        checks++;
        if (o.outValid !== 1'b0) begin failures++; $display("[TB] FAIL add_dup: out_valid got %b want 0 after drain", o.outValid); end
    endtask

    task automatic test_op_sweep();
        obs_t          o;
        beat_t         e;
        int            lane0Exp[$];
        int            k;
        logic [VW-1:0] a, b;
        lane0Exp = '{9, 3, 18, 2, 7, 5, 0, 0, 1};
        k = 0;
        for (int cyc = 0; cyc < 20 && lane0Exp.size() > 0; cyc++) begin
            a = rand_vec();
            b = rand_vec();
            if (k < 8) begin
                a[15:0] = 16'h0006; b[15:0] = 16'h0003;
                applyStimulus(1'b1, 3'(k), 4'b1111, a, b, 1'b1, o);
            end else if (k == 8) begin
                a[15:0] = 16'h8000; b[15:0] = 16'h0001;
                applyStimulus(1'b1, 3'd6, 4'b1111, a, b, 1'b1, o);
            end else begin
                applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, o);
            end
            if (o.accepted) k++;
            if (o.outFire) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++; $display("[TB] FAIL sweep_extra: unexpected beat res=%h", o.beat.res);
                end else begin
                    e = expQ.pop_front();
                    if (o.beat.res !== e.res || o.beat.zero !== e.zero || o.beat.mask !== e.mask) begin
                        failures++;
                        $display("[TB] FAIL sweep_beat: got res=%h zero=%b mask=%b want res=%h zero=%b mask=%b",
                                 o.beat.res, o.beat.zero, o.beat.mask, e.res, e.zero, e.mask);
                    end
                end
                checks++;
                if (int'(o.beat.res[15:0]) !== lane0Exp[0]) begin
                    failures++; $display("[TB] FAIL sweep_lane0: got %0d want %0d", o.beat.res[15:0], lane0Exp[0]);
                end
                void'(lane0Exp.pop_front());
            end
        end
        checks++;
        if (lane0Exp.size() != 0 || expQ.size() != 0) begin
            failures++; $display("[TB] FAIL sweep_drain: %0d results missing, want 0", lane0Exp.size());
        end
    endtask

    task automatic test_mask();
        obs_t o;
        applyStimulus(1'b1, 3'd4, 4'b0101, {4{16'h00FF}}, {4{16'h00FF}}, 1'b1, o);
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, o);
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, o);
        checks++;
        if (o.outValid !== 1'b1 || o.beat.res !== 64'h0000_00FF_0000_00FF || o.beat.zero !== 4'b0000 || o.beat.mask !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL mask_value: got v=%b res=%h zero=%b mask=%b want v=1 res=000000ff000000ff zero=0000 mask=0101",
                     o.outValid, o.beat.res, o.beat.zero, o.beat.mask);
        end
        expQ.delete();
    endtask

    task automatic test_backpressure();
        obs_t  o;
        beat_t e, held;
        int    sent = 0, got = 0, stallLeft = -1;
        bit    sawBlocked = 1'b0, prevStall = 1'b0;
        logic  ordy;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            ordy = !(stallLeft > 0);
            applyStimulus(sent < 5, 3'($urandom_range(0, 7)), 4'($urandom), rand_vec(), rand_vec(), ordy, o);
            if (o.accepted) sent++;
            if (!o.inReady) sawBlocked = 1'b1;
            if (prevStall) begin
                checks++;
                if (o.outValid !== 1'b1 || o.beat.res !== held.res || o.beat.zero !== held.zero || o.beat.mask !== held.mask) begin
                    failures++;
                    $display("[TB] FAIL bp_hold: got v=%b res=%h want v=1 res=%h", o.outValid, o.beat.res, held.res);
                end
            end
            prevStall = o.outValid && !ordy;
            held      = o.beat;
            if (o.outFire) begin
                got++;
                checks++;
                if (expQ.size() == 0) begin
                    failures++; $display("[TB] FAIL bp_extra: unexpected beat res=%h", o.beat.res);
                end else begin
                    e = expQ.pop_front();
                    if (o.beat.res !== e.res || o.beat.zero !== e.zero || o.beat.mask !== e.mask) begin
                        failures++; $display("[TB] FAIL bp_order: got res=%h want res=%h", o.beat.res, e.res);
                    end
                end
            end
            if (stallLeft > 0) stallLeft--;
            if (stallLeft == -1 && o.outFire) stallLeft = 3;
        end
        checks++;
        if (!sawBlocked) begin failures++; $display("[TB] FAIL bp_in_ready: never saw in_ready=0, want 0 when full"); end
        checks++;
        if (got != 5 || expQ.size() != 0) begin
            failures++; $display("[TB] FAIL bp_count: got %0d beats (%0d pending) want 5", got, expQ.size());
        end
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, o);
        checks++;
        if (o.outValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_dup: out_valid got %b want 0", o.outValid); end
    endtask

    task automatic test_throughput();
        obs_t  o;
        beat_t e;
        for (int t = 0; t < 12; t++) begin
            if (t < 8) applyStimulus(1'b1, 3'($urandom_range(0, 7)), 4'($urandom), rand_vec(), rand_vec(), 1'b1, o);
            else       applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, o);
            if (t < 8) begin
                checks++;
                if (o.accepted !== 1'b1) begin failures++; $display("[TB] FAIL tput_accept: cycle %0d got %b want 1", t, o.accepted); end
            end
            checks++;
            if (o.outValid !== ((t >= 2 && t < 10) ? 1'b1 : 1'b0)) begin
                failures++; $display("[TB] FAIL tput_valid: cycle %0d got %b want %b", t, o.outValid, (t >= 2 && t < 10));
            end
            if (o.outFire) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++; $display("[TB] FAIL tput_extra: unexpected beat res=%h", o.beat.res);
                end else begin
                    e = expQ.pop_front();
                    if (o.beat.res !== e.res || o.beat.zero !== e.zero || o.beat.mask !== e.mask) begin
                        failures++; $display("[TB] FAIL tput_beat: got res=%h zero=%b want res=%h zero=%b", o.beat.res, o.beat.zero, e.res, e.zero);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        obs_t  o;
        beat_t e;
        int    sent = 0, got = 0;
        for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
            applyStimulus((sent < 40) && ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 4'($urandom),
                          rand_vec(), rand_vec(), $urandom_range(0, 2) != 0, o);
            if (o.accepted) sent++;
            if (o.outFire) begin
                got++;
                checks++;
                if (expQ.size() == 0) begin
                    failures++; $display("[TB] FAIL rand_extra: unexpected beat res=%h", o.beat.res);
                end else begin
                    e = expQ.pop_front();
                    if (o.beat.res !== e.res || o.beat.zero !== e.zero || o.beat.mask !== e.mask) begin
                        failures++;
                        $display("[TB] FAIL rand_beat: got res=%h zero=%b mask=%b want res=%h zero=%b mask=%b",
                                 o.beat.res, o.beat.zero, o.beat.mask, e.res, e.zero, e.mask);
                    end
                end
            end
        end
        checks++;
        if (got != 40) begin failures++; $display("[TB] FAIL rand_count: got %0d beats want 40", got); end
    endtask

    task automatic test_reset_midflight();
        obs_t  o;
        beat_t e;
        int    got = 0;
        applyStimulus(1'b1, 3'd0, 4'b1111, rand_vec(), rand_vec(), 1'b1, o);
        applyStimulus(1'b1, 3'd5, 4'b1111, rand_vec(), rand_vec(), 1'b1, o);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_inflight: out_valid got %b want 1", out_valid); end
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0) begin
            failures++; $display("[TB] FAIL mid_reset: got v=%b res=%h want v=0 res=0", out_valid, out_result);
        end
        expQ.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 3'd2, 4'b1011, rand_vec(), rand_vec(), 1'b1, o);
        for (int cyc = 0; cyc < 6; cyc++) begin
            applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1, o);
            if (o.outFire) begin
                got++;
                checks++;
                if (expQ.size() == 0) begin
                    failures++; $display("[TB] FAIL mid_stale: unexpected beat res=%h", o.beat.res);
                end else begin
                    e = expQ.pop_front();
                    if (o.beat.res !== e.res || o.beat.zero !== e.zero || o.beat.mask !== e.mask) begin
                        failures++; $display("[TB] FAIL mid_beat: got res=%h want res=%h", o.beat.res, e.res);
                    end
                end
            end
        end
        checks++;
        if (got != 1) begin failures++; $display("[TB] FAIL mid_count: got %0d beats want 1", got); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_single_add();
        test_op_sweep();
        test_mask();
        test_backpressure();
        test_throughput();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
